mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single 19-bit SoC data-memory port between NREQ bus masters (CPU LSU, crypto_accel, FFT accel).
// - Round-robin grant with optional short bus lock for read-modify-write sequences.
// - Registers the winning request onto the memory port and routes read data back to the issuer.
// - Sits between the accelerator memory masters and the memory macro.
// PARAMETERS
// NREQ      3   number of requesters; index 0 = CPU, 1 = crypto, 2 = FFT
// AW        19  address width
// DW        19  data width
// LOCK_MAX  8   max consecutive grants to a locking requester before rotation is forced
// PORTS
// clk          in   1        system clock, all state on posedge
// rst_n        in   1        asynchronous active-low reset
// req_valid    in   NREQ     request present; held stable until accepted
// req_write    in   NREQ     1 = write, 0 = read
// req_lock     in   NREQ     keep grant for the next request of this requester
// req_addr     in   NREQ*AW  flattened; requester i at [i*AW +: AW]
// req_wdata    in   NREQ*DW  flattened; requester i at [i*DW +: DW]
// req_ready    out  NREQ     one-hot accept, combinational, this cycle
// rsp_valid    out  NREQ     one-hot read-data strobe
// rsp_rdata    out  DW       read data, shared by all requesters
// mem_valid    out  1        registered memory request
// mem_write    out  1        registered write enable
// mem_addr     out  AW       registered address
// mem_wdata    out  DW       registered write data
// mem_rdata    in   DW       memory read data, valid the cycle after mem_valid && !mem_write
// BEHAVIOUR
// - Reset: mem_valid/mem_write=0, mem_addr/mem_wdata=0, rsp_valid=0, rr_ptr=0, lock_owner=none, lock_cnt=0.
// - Reset mid-operation: the outstanding request and response are dropped; no rsp_valid after reset release.
// - Winner select (comb): if lock_owner=k, req_valid[k]=1 and lock_cnt<LOCK_MAX, winner=k.
//   Otherwise winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
// - req_ready[winner]=1 in cycle t only. At most one grant per cycle, no bubbles; no valid => no grant.
// - Edge ending t: mem_* <= winner's request, mem_valid <= 1. No grant => mem_valid <= 0; other mem_* hold.
// - Read latency: grant in t, mem_valid in t+1, rsp_valid[winner]=1 in t+2, rsp_rdata=mem_rdata (comb pass).
// - Writes return no response; write accepted in t is visible at memory in t+1.
// - Back-to-back reads from different requesters pipeline: rsp_valid is one-hot per cycle, in grant order.
// - rr_ptr: after every grant, rr_ptr <= (winner+1) mod NREQ, including locked grants.
// - Lock:
//   - grant with req_lock[w]=1 => lock_owner <= w; lock_cnt <= same owner ? lock_cnt+1 : 1.
//   - grant with req_lock[w]=0, or owner idle (req_valid[k]=0) in a cycle => lock released, lock_cnt <= 0.
//   - lock_cnt = LOCK_MAX => owner is skipped once via normal rr scan; lock_cnt resets to 0 on that grant.
//   - Worst-case wait for a non-locking requester: (NREQ-1)*LOCK_MAX grants.
// - Simultaneous: new lock request plus an existing different owner => existing owner keeps priority this cycle.
// - req_* of non-winners are ignored; requesters must hold them unchanged until ready.
// - Protocol violations (valid dropped before ready) are not detected; no error output.
// TESTING
// - Reset: all valid=0 -> mem_valid=0, rsp_valid=0, req_ready=0 for 5 cycles; then rr_ptr=0.
// - All three request every cycle, no lock -> grants 0,1,2,0,1,2...; mem_addr follows each requester's address 1 cycle later.
// - Crypto read 0x00100 while memory returns 0x0ABCD -> req_ready[1] at t, mem_valid at t+1, rsp_valid=3'b010 with 0x0ABCD at t+2.
// - CPU locks with req_lock=1 continuously, FFT also requesting -> 8 CPU grants, then 1 FFT grant, then CPU lock resumes.
// - CPU read, then crypto write 0x1A2B to 0x00200 in back-to-back cycles -> mem_write 0 then 1; only rsp_valid[0] pulses.
// - rst_n asserted the cycle after a read grant -> mem_valid=0 immediately; no rsp_valid after release; rr_ptr=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one registered data-memory port between NREQ bus masters
// (index 0 = CPU LSU, 1 = crypto accel, 2 = FFT accel).
//
// Arbitration is round-robin.  A requester that sets req_lock on a granted
// request keeps the port for its following requests (read-modify-write
// sequences) until it drops the lock, goes idle, or has taken LOCK_MAX
// consecutive grants, at which point one normal round-robin scan is forced.
//
// Handshake: a requester raises req_valid[i] with stable req_* fields and
// holds them until req_ready[i] is high in the same cycle; the request is
// transferred on that clock edge.  req_ready is combinational, one-hot, and
// asserted for at most one requester per cycle.  Reads are answered with a
// single-cycle rsp_valid[i] pulse two cycles after the grant; writes get no
// response.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/write/lock       per-requester request flags (NREQ bits)
//   req_addr / req_wdata       flattened, requester i at [i*AW +: AW] / [i*DW +: DW]
//   req_ready                  one-hot grant, combinational
//   rsp_valid / rsp_rdata      one-hot read strobe, shared read data
//   mem_valid/write/addr/wdata registered memory request
//   mem_rdata                  memory read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 19,
  parameter int DW       = 19,
  parameter int LOCK_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               mem_valid,
  output logic               mem_write,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
  localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

  // arbitration state
  logic [IW-1:0] rr_ptr;
  logic          lock_held;
  logic [IW-1:0] lock_owner;
  logic [CW-1:0] lock_cnt;

  // response tracking: id of the request on the memory port, and the
  // read whose data is on mem_rdata this cycle
  logic [IW-1:0] mem_id;
  logic          rsp_pend;
  logic [IW-1:0] rsp_id;

  // combinational arbitration results
  logic          grant;
  logic [IW-1:0] winner;
  logic [IW-1:0] scan_idx;
  logic          lock_expired;
  logic          lock_hit;
  logic [IW-1:0] rr_next;
  logic          lock_held_n;
  logic [IW-1:0] lock_owner_n;
  logic [CW-1:0] lock_cnt_n;

  // Winner select.  The round-robin scan runs from the far end back to
  // rr_ptr so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    grant        = 1'b0;
    winner       = '0;
    scan_idx     = '0;
    lock_expired = lock_held && (lock_cnt == CNT_MAX);
    lock_hit     = lock_held && req_valid[lock_owner] && !lock_expired;
    if (lock_hit) begin
      grant  = 1'b1;
      winner = lock_owner;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        scan_idx = IW'((int'(rr_ptr) + k) % NREQ);
        if (req_valid[scan_idx]) begin
          grant  = 1'b1;
          winner = scan_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  assign rr_next = (winner == LAST_ID) ? '0 : winner + 1'b1;

  // Lock bookkeeping.  An idle owner loses the lock; a grant then decides
  // the final state.  The grant that follows an exhausted lock budget
  // clears the count, so an owner that wins that scan starts afresh.
  always_comb begin
    lock_held_n  = lock_held;
    lock_owner_n = lock_owner;
    lock_cnt_n   = lock_cnt;
    if (lock_held && !req_valid[lock_owner]) begin
      lock_held_n = 1'b0;
      lock_cnt_n  = '0;
    end
    if (grant) begin
      if (lock_expired && (winner == lock_owner)) begin
        lock_held_n = 1'b0;
        lock_cnt_n  = '0;
      end else if (req_lock[winner]) begin
        lock_held_n  = 1'b1;
        lock_owner_n = winner;
        lock_cnt_n   = (lock_held && (lock_owner == winner)) ? lock_cnt + 1'b1 : CW'(1);
      end else begin
        lock_held_n = 1'b0;
        lock_cnt_n  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      lock_held  <= 1'b0;
      lock_owner <= '0;
      lock_cnt   <= '0;
      mem_valid  <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_id     <= '0;
      rsp_pend   <= 1'b0;
      rsp_id     <= '0;
    end else begin
      lock_held  <= lock_held_n;
      lock_owner <= lock_owner_n;
      lock_cnt   <= lock_cnt_n;
      mem_valid  <= grant;
      if (grant) begin
        rr_ptr    <= rr_next;
        mem_write <= req_write[winner];
        mem_addr  <= req_addr[winner*AW +: AW];
        mem_wdata <= req_wdata[winner*DW +: DW];
        mem_id    <= winner;
      end
      // memory answers a read one cycle after it sits on the port
      rsp_pend <= mem_valid && !mem_write;
      rsp_id   <= mem_id;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_pend) rsp_valid[rsp_id] = 1'b1;
  end

  assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int NREQ     = 3;
  localparam int AW       = 19;
  localparam int DW       = 19;
  localparam int LOCK_MAX = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid, req_write, req_lock, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rsp_rdata, mem_wdata;
  logic [DW-1:0]      mem_rdata = '0;
  logic               mem_valid, mem_write;
  logic [AW-1:0]      mem_addr;

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- memory macro and its reference image ----------------
  logic [DW-1:0] tb_mem[logic [AW-1:0]];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    logic [DW-1:0] x;
    x = DW'(a) * 19'd5 + 19'h155;
    return x;
  endfunction

  always @(posedge clk) begin
    if (mem_valid) begin
      if (mem_write) tb_mem[mem_addr] = mem_wdata;
      else mem_rdata <= tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : dflt(mem_addr);
    end
  end

  // ---------------- reference model + scoreboard queues ----------------
  typedef struct { int due; logic w; logic [AW-1:0] a; logic [DW-1:0] d; } mem_exp_t;
  typedef struct { int due; int id; logic [DW-1:0] d; } rsp_exp_t;
  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];

  int m_rr = 0, m_own = -1, m_cnt = 0, m_w;
  logic m_exp;
  logic [NREQ-1:0] exp_rdy;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d, m_rd;

  // Spec rules evaluated once per cycle on stable inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_rr = 0; m_own = -1; m_cnt = 0;
      mem_q.delete();
      rsp_q.delete();
    end else begin
      m_w   = -1;
      m_exp = (m_own >= 0) && (m_cnt == LOCK_MAX);
      if (m_own >= 0 && req_valid[m_own] && m_cnt < LOCK_MAX) m_w = m_own;
      else
        for (int k = 0; k < NREQ; k++)
          if (m_w < 0 && req_valid[(m_rr + k) % NREQ]) m_w = (m_rr + k) % NREQ;
      exp_rdy = '0;
      if (m_w >= 0) exp_rdy[m_w] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      if (m_own >= 0 && !req_valid[m_own]) begin m_own = -1; m_cnt = 0; end
      if (m_w >= 0) begin
        m_a = req_addr[m_w*AW +: AW];
        m_d = req_wdata[m_w*DW +: DW];
        mem_q.push_back('{cyc + 1, req_write[m_w], m_a, m_d});
        if (req_write[m_w]) ref_mem[m_a] = m_d;
        else begin
          m_rd = ref_mem.exists(m_a) ? ref_mem[m_a] : dflt(m_a);
          rsp_q.push_back('{cyc + 2, m_w, m_rd});
        end
        m_rr = (m_w + 1) % NREQ;
        if (m_exp && m_w == m_own) begin m_own = -1; m_cnt = 0; end
        else if (req_lock[m_w]) begin
          m_cnt = (m_own == m_w) ? m_cnt + 1 : 1;
          m_own = m_w;
        end else begin m_own = -1; m_cnt = 0; end
      end
    end
  end

  // ---------------- monitor ----------------
  mem_exp_t me;
  rsp_exp_t re;
  logic [NREQ-1:0] exp_oh;

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (mem_valid) begin
        if (mem_q.size() == 0) fail_evt("mem_unexpected", mem_addr, 0);
        else begin
          me = mem_q.pop_front();
          check("mem_latency", cyc, me.due);
          check("mem_write", mem_write, me.w);
          check("mem_addr", mem_addr, me.a);
          check("mem_wdata", mem_wdata, me.d);
        end
      end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        fail_evt("mem_missing", 0, mem_q[0].a);
        void'(mem_q.pop_front());
      end
      if (rsp_valid != '0) begin
        if (rsp_q.size() == 0) fail_evt("rsp_unexpected", rsp_valid, 0);
        else begin
          re = rsp_q.pop_front();
          exp_oh = '0;
          exp_oh[re.id] = 1'b1;
          check("rsp_latency", cyc, re.due);
          check("rsp_valid", rsp_valid, exp_oh);
          check("rsp_rdata", rsp_rdata, re.d);
        end
      end else if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
        fail_evt("rsp_missing", 0, rsp_q[0].id);
        void'(rsp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [NREQ-1:0] k_mask, k_lock_force;
  int k_fill, k_lock, k_wr;
  logic [NREQ-1:0] act_log[$];

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i, input logic w, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_lock[i]  = lk;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_lock  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Random masters: a granted request is retired and, per knobs, replaced.
  task automatic run(input int n);
    logic [NREQ-1:0] g;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      g = req_ready;
      if (g != '0) act_log.push_back(g);
      next_cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && k_mask[i] && $urandom_range(99) < k_fill)
          new_req(i, $urandom_range(99) < k_wr,
                  k_lock_force[i] || ($urandom_range(99) < k_lock),
                  AW'($urandom_range(31)), DW'($urandom));
      end
    end
  endtask

  task automatic drain();
    k_mask = '0;
    run(8);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b1; req_valid = '0; req_write = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0;
    k_mask = '0; k_lock_force = '0; k_fill = 0; k_lock = 0; k_wr = 0;
    tb_mem[19'h00100]  = 19'h0ABCD;
    ref_mem[19'h00100] = 19'h0ABCD;
    #1 rst_n = 1'b0;

    // reset values, then five idle cycles
    @(negedge clk);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle_mem_valid", mem_valid, 0);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_req_ready", req_ready, 0);
    end
    next_cyc();

    // all three request every cycle, no lock: grants 0,1,2,0,...
    k_mask = 3'b111; k_fill = 100; k_lock = 0; k_wr = 50; k_lock_force = '0;
    act_log.delete();
    run(10);
    check("rr_len", act_log.size() >= 9, 1);
    if (act_log.size() >= 9)
      for (int k = 0; k < 9; k++) check("rr_order", act_log[k], 3'b001 << (k % 3));
    drain();

    // crypto read of a preloaded word
    do_reset();
    new_req(1, 1'b0, 1'b0, 19'h00100, DW'($urandom));
    @(negedge clk);
    check("crypto_ready", req_ready, 3'b010);
    next_cyc();
    req_valid[1] = 1'b0;
    repeat (4) next_cyc();

    // CPU locks continuously, FFT competing
    do_reset();
    k_mask = 3'b101; k_fill = 100; k_lock = 0; k_wr = 50; k_lock_force = 3'b001;
    act_log.delete();
    run(22);
    check("lock_len", act_log.size() >= 18, 1);
    if (act_log.size() >= 18)
      for (int k = 0; k < 18; k++)
        check("lock_seq", act_log[k], ((k % 9) == 8) ? 3'b100 : 3'b001);
    k_lock_force = '0;
    drain();

    // CPU read then crypto write back-to-back, FFT reads the written word
    do_reset();
    new_req(0, 1'b0, 1'b0, 19'h00300, DW'($urandom));
    next_cyc();
    req_valid[0] = 1'b0;
    new_req(1, 1'b1, 1'b0, 19'h00200, 19'h01A2B);
    check("b2b_first_write", mem_write, 0);
    next_cyc();
    req_valid[1] = 1'b0;
    new_req(2, 1'b0, 1'b0, 19'h00200, DW'($urandom));
    check("b2b_second_write", mem_write, 1);
    check("b2b_second_addr", mem_addr, 19'h00200);
    check("b2b_second_wdata", mem_wdata, 19'h01A2B);
    check("b2b_cpu_rsp", rsp_valid, 3'b001);
    next_cyc();
    req_valid[2] = 1'b0;
    check("b2b_no_write_rsp", rsp_valid, 3'b000);
    repeat (4) next_cyc();

    // reset the cycle after a read grant
    do_reset();
    new_req(0, 1'b0, 1'b0, 19'h00010, DW'($urandom));
    @(negedge clk);
    check("rst_mid_grant", req_ready, 3'b001);
    next_cyc();
    req_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_valid", mem_valid, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_mid_no_rsp", rsp_valid, 0);
    end
    next_cyc();
    for (int i = 0; i < NREQ; i++) new_req(i, 1'b1, 1'b0, AW'(i + 4), DW'($urandom));
    @(negedge clk);
    check("rr_after_rst", req_ready, 3'b001);
    next_cyc();
    req_valid[0] = 1'b0;
    drain();

    // randomized traffic with locks
    do_reset();
    k_mask = 3'b111; k_fill = 60; k_lock = 30; k_wr = 40; k_lock_force = '0;
    run(600);
    drain();
    repeat (4) next_cyc();

    check("mem_q_empty", mem_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
